line_window_3x3: RTL and testbench
==================================

Name: line_window_3x3

Overview:
- Streaming 3x3 neighbourhood generator for the convolutional blur path.
- Accepts raster-order pixels and writes each line into two single-clock line RAMs, one write port and one read port each.
- Reads back the two previous rows at the same column and presents a complete 3x3 window to the downstream blur kernel.
- Interior pixels only: the output image is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

Parameters:
- DATA_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 640, pixels per line; also the line RAM depth
- IMG_HEIGHT, 480, lines per frame
- ADDR_WIDTH, 10, line RAM address and column counter width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH
- ROW_WIDTH, 9, row counter width; must satisfy 2^ROW_WIDTH >= IMG_HEIGHT

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data is a valid pixel this cycle; gaps allowed, no backpressure
- in_sof  in  1  start of frame; qualified by in_valid; this pixel is (row 0, col 0)
- in_data  in  DATA_WIDTH  pixel value
- out_valid  out  1  out_window is a valid interior window
- out_window  out  9*DATA_WIDTH  packed window; element k=3*i+j at [DATA_WIDTH*k +: DATA_WIDTH]; i=0 is the oldest row, j=0 the leftmost column
- out_row  out  ROW_WIDTH  row of the window centre
- out_col  out  ADDR_WIDTH  column of the window centre

Behaviour:
- Reset (synchronous, active-high): col=0, row=0, all pipeline valid bits 0; out_valid, out_window, out_row and out_col all 0. Line RAM contents are not cleared.
- Counters advance only on in_valid.
  - col increments; at col == IMG_WIDTH-1 it wraps to 0 and row increments.
  - At row == IMG_HEIGHT-1 with col == IMG_WIDTH-1, row wraps to 0.
  - in_sof with in_valid forces this pixel to (0,0); the next pixel is (0,1), regardless of the prior count.
- Stage 0 (input cycle, valid pixel at (r,c)):
  - Issue read address c to both RAMs.
  - RAM0 holds row r-1; RAM1 holds row r-2.
  - Register pixel, c, r and valid into stage 1.
- Stage 1 (one cycle later): RAM outputs are available (1-cycle read latency).
  - Write RAM0[c] <= stage-1 pixel.
  - Write RAM1[c] <= RAM0 read data.
  - Write occurs the cycle after the read at the same address, so the read returns old-row data.
  - Column triple {RAM1 out, RAM0 out, pixel} shifts into the 3x3 shift register only when stage-1 valid is set.
- Output register (stage 2):
  - out_valid = stage-1 valid AND r >= 2 AND c >= 2.
  - out_row = r-1, out_col = c-1.
  - out_window is the updated shift-register contents.
  - Latency: input pixel (r,c) to its window on the output is 2 cycles.
- out_valid is a 1-cycle pulse per qualifying input. out_window, out_row and out_col hold their values when out_valid=0.
- Boundaries:
  - At c < 2, shift-register columns are stale from the previous line and the output is suppressed.
  - Rows 0-1 after reset or sof are suppressed, so stale RAM content is never exposed.
- Gaps in in_valid freeze the window and counters; RAM reads are harmless.
- Reset mid-frame flushes the pipeline next cycle with no output; the stream resumes at (0,0).
- Simultaneous in_sof and a counter wrap: in_sof wins.

Decomposition:
- Shared package holds:
  - DATA_WIDTH, IMG_WIDTH and IMG_HEIGHT defaults
  - a window-index helper constant WIN_IDX(i,j) = 3*i+j
- One sub-module, line_ram: single-clock RAM with write enable, separate read and write addresses, and registered read data. Instantiate it twice.

Test Plan:
All scenarios use IMG_WIDTH=5, IMG_HEIGHT=4, pixel = 16*row+col.
- Reset then one full frame with in_sof on the first pixel -> exactly 6 out_valid pulses. The first occurs 2 cycles after input (2,2), with out_row=1, out_col=1, elements k0=0x00, k4=0x11, k8=0x22.
- Same frame with in_valid deasserted every other cycle -> identical 6 windows and values; each window appears 2 cycles after its triggering pixel.
- Two back-to-back frames -> frame 2 produces the same 6 windows. The last window of frame 1 has centre (2,3) and k8=0x34.
- in_sof asserted mid-frame at (2,1) -> counters reset; no out_valid until the new (2,2), which yields the correct window of new-frame data.
- reset asserted for 1 cycle while input is at (3,2) -> out_valid=0 in the following cycles. After restarting with in_sof, the first window is again (1,1) with k4=0x11.
- Rows 0-1 and columns 0-1 of every row -> out_valid never asserted (checked by a scoreboard over the whole frame).

Source files
------------

// File: rtl/line_window_3x3_pkg.sv
// Shared defaults and window indexing helpers for the 3x3 line window generator.
package line_window_3x3_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_IMG_WIDTH  = 640;
    localparam int unsigned DEF_IMG_HEIGHT = 480;

    localparam int unsigned WIN_DIM  = 3;
    localparam int unsigned WIN_SIZE = WIN_DIM * WIN_DIM;

    // Flat window element index: i = row (0 oldest), j = column (0 leftmost).
    function automatic int unsigned win_idx(input int unsigned i, input int unsigned j);
        return WIN_DIM * i + j;
    endfunction

endpackage

// File: rtl/line_window_3x3_line_ram.sv
// Single-clock line RAM: one write port, one read port, registered read data.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data, one cycle after raddr_i (old data on same-cycle write)
module line_ram
    import line_window_3x3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_IMG_WIDTH,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; consumers gate stale contents themselves.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_o <= mem[raddr_i];
    end

endmodule

// File: rtl/line_window_3x3.sv
// Streaming 3x3 neighbourhood generator: two line RAMs hold the previous two
// rows, a 3x3 shift register forms the window, only interior windows are emitted.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   in_valid    - pixel strobe (gaps allowed, no backpressure)
//   in_sof      - start of frame, qualified by in_valid
//   in_data     - pixel value
//   out_valid   - one-cycle pulse per interior window
//   out_window  - element 3*i+j at [DATA_WIDTH*k +: DATA_WIDTH], i=0 oldest row
//   out_row     - window centre row
//   out_col     - window centre column
module line_window_3x3
    import line_window_3x3_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned ROW_WIDTH  = 9
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic                           in_sof,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    output logic [WIN_SIZE*DATA_WIDTH-1:0] out_window,
    output logic [ROW_WIDTH-1:0]           out_row,
    output logic [ADDR_WIDTH-1:0]          out_col
);

    localparam int unsigned WIN_WIDTH = WIN_SIZE * DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] col_q, col_d, cur_col_c;
    logic [ROW_WIDTH-1:0]  row_q, row_d, cur_row_c;

    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_pix_q;
    logic [ADDR_WIDTH-1:0] s1_col_q;
    logic [ROW_WIDTH-1:0]  s1_row_q;

    logic [DATA_WIDTH-1:0] ram0_rd, ram1_rd;
    logic [DATA_WIDTH-1:0] new_col_c [WIN_DIM];
    logic [WIN_WIDTH-1:0]  win_q, win_d;
    logic                  win_ok_c;

    // Position of the current pixel (sof overrides the count) and next count.
    always_comb begin
        cur_col_c = col_q;
        cur_row_c = row_q;
        if (in_valid && in_sof) begin
            cur_col_c = '0;
            cur_row_c = '0;
        end
        col_d = col_q;
        row_d = row_q;
        if (in_valid) begin
            if (cur_col_c == ADDR_WIDTH'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (cur_row_c == ROW_WIDTH'(IMG_HEIGHT - 1)) ? '0
                                                                  : cur_row_c + ROW_WIDTH'(1);
            end else begin
                col_d = cur_col_c + ADDR_WIDTH'(1);
                row_d = cur_row_c;
            end
        end
    end

    // RAM0 holds row r-1, RAM1 row r-2. Read at stage 0, write back at stage 1,
    // so each read sees the row before the current one is written in.
    line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram0 (
        .clk     (clk),
        .we_i    (s1_valid_q),
        .waddr_i (s1_col_q),
        .wdata_i (s1_pix_q),
        .raddr_i (cur_col_c),
        .rdata_o (ram0_rd)
    );

    line_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram1 (
        .clk     (clk),
        .we_i    (s1_valid_q),
        .waddr_i (s1_col_q),
        .wdata_i (ram0_rd),
        .raddr_i (cur_col_c),
        .rdata_o (ram1_rd)
    );

    // Shift the window left by one column and insert the new column triple.
    always_comb begin
        new_col_c[0] = ram1_rd;
        new_col_c[1] = ram0_rd;
        new_col_c[2] = s1_pix_q;
        win_d        = win_q;
        if (s1_valid_q) begin
            for (int unsigned i = 0; i < WIN_DIM; i++) begin
                win_d[DATA_WIDTH*win_idx(i, 0) +: DATA_WIDTH] = win_q[DATA_WIDTH*win_idx(i, 1) +: DATA_WIDTH];
                win_d[DATA_WIDTH*win_idx(i, 1) +: DATA_WIDTH] = win_q[DATA_WIDTH*win_idx(i, 2) +: DATA_WIDTH];
                win_d[DATA_WIDTH*win_idx(i, 2) +: DATA_WIDTH] = new_col_c[i];
            end
        end
    end

    // Rows 0-1 would expose stale RAM data and columns 0-1 stale window columns.
    assign win_ok_c = s1_valid_q && (s1_row_q >= ROW_WIDTH'(2)) && (s1_col_q >= ADDR_WIDTH'(2));

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q      <= '0;
            row_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            win_q      <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_pix_q <= in_data;
                s1_col_q <= cur_col_c;
                s1_row_q <= cur_row_c;
            end
            win_q     <= win_d;
            out_valid <= win_ok_c;
            if (win_ok_c) begin
                out_window <= win_d;
                out_row    <= s1_row_q - ROW_WIDTH'(1);
                out_col    <= s1_col_q - ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 on a 5x4 image with pixel = 16*row+col.
module tb_line_window_3x3;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 5;
    localparam int unsigned IH = 4;
    localparam int unsigned AW = 3;
    localparam int unsigned RW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_sof;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic [9*DW-1:0] out_window;
    logic [RW-1:0]   out_row;
    logic [AW-1:0]   out_col;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    // Model state: previous step's input and the expected held outputs.
    bit              pv;
    int              pr, pc;
    logic            exp_v;
    logic [9*DW-1:0] exp_win;
    logic [RW-1:0]   exp_row;
    logic [AW-1:0]   exp_col;

    line_window_3x3 #(
        .DATA_WIDTH (DW),
        .IMG_WIDTH  (IW),
        .IMG_HEIGHT (IH),
        .ADDR_WIDTH (AW),
        .ROW_WIDTH  (RW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_window (out_window),
        .out_row    (out_row),
        .out_col    (out_col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [9*DW-1:0] obs, input logic [9*DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs, then check outputs produced by the previous step's pixel.
    task automatic step(input bit rst, input bit v, input bit sof, input int r, input int c);
        reset    = rst;
        in_valid = v;
        in_sof   = sof;
        in_data  = DW'(16 * r + c);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_v   = 1'b0;
            exp_win = '0;
            exp_row = '0;
            exp_col = '0;
        end else if (pv && pr >= 2 && pc >= 2) begin
            exp_v   = 1'b1;
            exp_row = RW'(pr - 1);
            exp_col = AW'(pc - 1);
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    exp_win[DW*(3*i+j) +: DW] = DW'(16 * (pr - 2 + i) + (pc - 2 + j));
        end else begin
            exp_v = 1'b0;
        end
        chk("out_valid", 72'(out_valid), 72'(exp_v));
        chk("out_window", out_window, exp_win);
        chk("out_row", 72'(out_row), 72'(exp_row));
        chk("out_col", 72'(out_col), 72'(exp_col));
        if (out_valid === 1'b1) pulses++;
        pv = v && !rst;
        pr = r;
        pc = c;
    endtask

    // Raster indices first..last of a frame, optional sof on the first, optional gap after each.
    task automatic send_range(input int first, input int last, input bit gap, input bit sof_first);
        for (int k = first; k <= last; k++) begin
            step(1'b0, 1'b1, sof_first && (k == first), k / IW, k % IW);
            if (gap) step(1'b0, 1'b0, 1'b0, k / IW, k % IW);
        end
    endtask

    task automatic flush();
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        logic [DW-1:0] k0, k4, k8;
        pv = 1'b0; pr = 0; pc = 0;
        exp_v = 1'b0; exp_win = '0; exp_row = '0; exp_col = '0;
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);

        // Full frame; first window lands after the (2,3) input cycle
        pulses = 0;
        send_range(0, 13, 1'b0, 1'b1);
        k0 = out_window[0 +: DW];
        k4 = out_window[4*DW +: DW];
        k8 = out_window[8*DW +: DW];
        chk("first_row", 72'(out_row), 72'(1));
        chk("first_col", 72'(out_col), 72'(1));
        chk("first_k0", 72'(k0), 72'(8'h00));
        chk("first_k4", 72'(k4), 72'(8'h11));
        chk("first_k8", 72'(k8), 72'(8'h22));
        send_range(14, 19, 1'b0, 1'b0);
        flush();
        chk("frame_pulses", 72'(pulses), 72'(6));

        // Same frame with a gap after every pixel
        pulses = 0;
        send_range(0, 19, 1'b1, 1'b1);
        flush();
        chk("gap_pulses", 72'(pulses), 72'(6));

        // Back-to-back frames
        pulses = 0;
        send_range(0, 19, 1'b0, 1'b1);
        send_range(0, 0, 1'b0, 1'b1);
        k8 = out_window[8*DW +: DW];
        chk("last_valid", 72'(out_valid), 72'(1));
        chk("last_row", 72'(out_row), 72'(2));
        chk("last_col", 72'(out_col), 72'(3));
        chk("last_k8", 72'(k8), 72'(8'h34));
        send_range(1, 19, 1'b0, 1'b0);
        flush();
        chk("b2b_pulses", 72'(pulses), 72'(12));

        // sof mid-frame at what would have been (2,1)
        pulses = 0;
        send_range(0, 10, 1'b0, 1'b1);
        send_range(0, 19, 1'b0, 1'b1);
        flush();
        chk("sof_mid_pulses", 72'(pulses), 72'(6));

        // Reset while input is at (3,2), then restart
        pulses = 0;
        send_range(0, 16, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 3, 2);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("pre_reset_pulses", 72'(pulses), 72'(3));
        pulses = 0;
        send_range(0, 13, 1'b0, 1'b1);
        k4 = out_window[4*DW +: DW];
        chk("restart_row", 72'(out_row), 72'(1));
        chk("restart_col", 72'(out_col), 72'(1));
        chk("restart_k4", 72'(k4), 72'(8'h11));
        send_range(14, 19, 1'b0, 1'b0);
        flush();
        chk("restart_pulses", 72'(pulses), 72'(6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
